load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the pipeline MEM stage and the word-only data memory. It turns RV32I
//  loads and stores into word accesses. Sub-word stores use an internal read-modify-write,
//  and loads are extracted and sign/zero-extended. Single outstanding request; a
//  valid/ready request handshake and a one-cycle response pulse.
// PARAMETERS
//  DATA_WIDTH  32             data word width (fixed 32 for RV32I)
//  ADDR_WIDTH  32             byte address width
//  DMEM_BASE   32'h02000000   lowest valid data-memory byte address
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   LSU can accept (high only in IDLE)
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; the low byte/half is used for SB/SH
//  resp_valid   out  1   one-cycle pulse: request complete
//  resp_rdata   out  32  extended load data (0 for stores and errors)
//  resp_err     out  1   valid with resp_valid: bad address/funct3/alignment
//  mem_wr_en    out  1   data memory write enable
//  mem_addr     out  32  word-aligned byte address {addr[31:2],2'b00}
//  mem_wr_data  out  32  full word to write
//  mem_rd_data  in   32  combinational read data (valid when mem_wr_en=0)
// BEHAVIOUR
//  Reset: FSM=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_wr_en=0;
//   mem_addr=0; mem_wr_data=0. A request in flight is dropped.
//   No write is issued in the cycle after rst deasserts.
//  States: IDLE, LOAD, RMW_RD, WRITE.
//  IDLE: accept when req_valid&&req_ready (edge N). Register addr, funct3, we and wdata.
//   The next state is chosen at accept:
//   - error (addr<DMEM_BASE, funct3 in {011,110,111}, store with funct3[2]=1, misaligned
//     per CONFIGURATION) -> stay IDLE; resp_valid=1, resp_err=1, rdata=0 at N+1; no mem access.
//   - load  -> LOAD
//   - SW    -> WRITE
//   - SB/SH -> RMW_RD
//  LOAD: drive mem_addr, mem_wr_en=0. Capture mem_rd_data, extract the lane by addr[1:0]
//   (byte lane = addr[1:0], half lane = addr[1]), and extend: B/H sign-extend, BU/HU
//   zero-extend. Go to IDLE; resp_valid=1 at N+2.
//  RMW_RD: drive mem_addr, mem_wr_en=0. Latch the old word, merge the new byte/half into
//   its lane, then go to WRITE.
//  WRITE: mem_wr_en=1 for exactly one cycle with mem_addr and the merged word. Go to IDLE.
//   resp_valid=1 at N+2 for SW and N+3 for SB/SH.
//  mem_* outputs are 0 whenever the FSM is in IDLE.
//  resp_valid is high for one cycle only; req_ready is already high in that cycle, so a
//   back-to-back accept is legal.
//  req_valid while busy is ignored; the requester must hold it until req_ready.
//  Lane merge keeps all other bytes of the old word bit-exact.
//  Wrap-around: addresses are not incremented; no access spans two words.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H/HU with addr[0]!=0, or W with addr[1:0]!=0, is an error
//   (resp_err=1, no memory access).
//  MISALIGN_TRAP_EN undefined: never flags misalignment. The offending low bits are
//   cleared (H: addr[0]=0; W: addr[1:0]=0) and the access proceeds normally.
// TESTING
//  1 SW 0x02000008 <- 0xDEADBEEF, then LW 0x02000008 -> resp_rdata=0xDEADBEEF, err=0,
//    load resp 2 cycles after accept.
//  2 Word=0x11223344; SB 0x02000009 <- 0xAA -> word=0x1122AA44; mem_wr_en high for 1 cycle.
//    resp at N+3.
//  3 Word=0x80F0017F; LB @+0 -> 0x0000007F; LB @+1 -> 0x00000001; LB @+2 -> 0xFFFFFFF0;
//    LBU @+3 -> 0x00000080; LH @+2 -> 0xFFFF80F0; LHU @+2 -> 0x000080F0.
//  4 LW 0x00001000 (below DMEM_BASE) -> resp_err=1, rdata=0 at N+1; mem_wr_en never set.
//  5 LH 0x02000005: with MISALIGN_TRAP_EN -> err=1, no access; without it -> reads the
//    half at 0x02000004.
//  6 rst asserted in RMW_RD of SH -> no write occurs, all outputs reset, memory unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory: RMW for SB/SH, extended loads.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses return an error instead.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DMEM_BASE = 32'h0200_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  typedef enum logic [1:0] {StIdle, StLoad, StRmwRd, StWrite} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, req_addr_adj;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] load_ext, merged;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  is_half, is_word, bad_funct3, misalign_err, req_err;

  assign is_half    = (req_funct3_i[1:0] == 2'b01);
  assign is_word    = (req_funct3_i[1:0] == 2'b10);
  assign bad_funct3 = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                      (req_funct3_i == 3'b111);

`ifdef MISALIGN_TRAP_EN
  assign misalign_err = (is_half && req_addr_i[0]) || (is_word && (req_addr_i[1:0] != 2'b00));
  assign req_addr_adj = req_addr_i;
`else
  assign misalign_err = 1'b0;
  // Misaligned accesses are silently aligned down to their natural boundary.
  always_comb begin
    req_addr_adj = req_addr_i;
    if (is_half) req_addr_adj[0] = 1'b0;
    if (is_word) req_addr_adj[1:0] = 2'b00;
  end
`endif

  assign req_err = (req_addr_i < DMEM_BASE) || bad_funct3 || (req_we_i && req_funct3_i[2]) ||
                   misalign_err;

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   byte_sel = mem_rd_data_i[7:0];
      2'b01:   byte_sel = mem_rd_data_i[15:8];
      2'b10:   byte_sel = mem_rd_data_i[23:16];
      default: byte_sel = mem_rd_data_i[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];

    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_rd_data_i;
    endcase

    merged = mem_rd_data_i;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      unique case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d   = req_addr_adj;
          funct3_d = req_funct3_i;
          wdata_d  = req_wdata_i;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we_i) begin
            state_d = StLoad;
          end else if (is_word) begin
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
        state_d      = StIdle;
      end
      StRmwRd: begin
        wdata_d = merged;
        state_d = StWrite;
      end
      StWrite: begin
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign mem_wr_en_o   = (state_q == StWrite);
  assign mem_addr_o    = (state_q != StIdle) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wr_data_o = (state_q == StWrite) ? wdata_q : '0;
  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;
  assign resp_rdata_o  = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory model plus byte-level reference model.
// Latency L means resp_valid is seen L clock edges after the accepting edge.
module tb_load_store_unit;

  localparam logic [31:0] Base  = 32'h0200_0000;
  localparam logic [31:0] Top   = 32'h0200_0100;
  localparam int          Words = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_err, mem_wr_en;
  logic [31:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;

  logic [31:0] mem     [Words];
  logic [31:0] ref_mem [Words];
  int          wr_count = 0;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_data = 32'h0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_wr_en_o  (mem_wr_en),
    .mem_addr_o   (mem_addr),
    .mem_wr_data_o(mem_wr_data),
    .mem_rd_data_i(mem_rd_data)
  );

  always_comb begin
    mem_rd_data = 32'h0;
    if (mem_addr >= Base && mem_addr < Top) mem_rd_data = mem[mem_addr[7:2]];
  end

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    if (mem_wr_en) begin
      wr_count <= wr_count + 1;
      if (mem_addr >= Base && mem_addr < Top) mem[mem_addr[7:2]] <= mem_wr_data;
    end
  end

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 6'(idx); poke_data = data;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference: byte-addressed view of the RV32I rules, updates ref_mem for stores.
  task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic err,
                           output logic [31:0] rdata, output int lat);
    logic [31:0] a, word, mask;
    int size, off, w;
    a = addr;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (addr < Base) || (f3 == 3'b011) || (f3 >= 3'b110) || (we && f3 >= 3'b100);
`ifdef MISALIGN_TRAP_EN
    if (addr % size != 0) err = 1'b1;
`else
    a = addr - addr % size;
`endif
    rdata = 32'h0;
    lat = 1;
    if (!err) begin
      w = int'((a - Base) / 4);
      off = int'(a % 4);
      word = ref_mem[w];
      if (!we) begin
        rdata = word >> (8 * off);
        if (size == 1) rdata = rdata & 32'hFF;
        if (size == 2) rdata = rdata & 32'hFFFF;
        if (f3 == 3'b000 && rdata[7])  rdata = rdata | 32'hFFFF_FF00;
        if (f3 == 3'b001 && rdata[15]) rdata = rdata | 32'hFFFF_0000;
        lat = 2;
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'hFFFF : 32'hFF;
        ref_mem[w] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        lat = (size == 4) ? 2 : 3;
      end
    end
  endtask

  // Drives one request and reports what the DUT did; bounded waits throughout.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output int nwr, output logic ready_at_resp,
                       output logic idle_ok);
    int wr0, guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    wr0 = wr_count;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    err = resp_err;
    rdata = resp_rdata;
    nwr = wr_count - wr0;
    ready_at_resp = req_ready;
    idle_ok = (mem_wr_en === 1'b0) && (mem_addr === 32'h0) && (mem_wr_data === 32'h0);
  endtask

  task automatic test_reset;
    int wr0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr0 = wr_count;
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_wr_en} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl got rdy/vld/err/we=%b exp 1000",
               {req_ready, resp_valid, resp_err, mem_wr_en});
    end
    vectors++;
    if (resp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata got %h exp 0", resp_rdata);
    end
    vectors++;
    if ({mem_addr, mem_wr_data} !== 64'h0) begin
      miscompares++; $display("FAIL reset_mem got addr %h data %h exp 0", mem_addr, mem_wr_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (wr_count !== wr0) begin
      miscompares++; $display("FAIL reset_nowrite got %0d writes exp 0", wr_count - wr0);
    end
  endtask

  task automatic test_sw_lw;
    logic e, ee, rdy, idl; logic [31:0] d, ed; int l, el, n;
    ref_model(1'b1, 3'b010, 32'h0200_0008, 32'hDEAD_BEEF, ee, ed, el);
    issue(1'b1, 3'b010, 32'h0200_0008, 32'hDEAD_BEEF, e, d, l, n, rdy, idl);
    vectors++;
    if ({e, l, n} !== {1'b0, 2, 1}) begin
      miscompares++; $display("FAIL sw err/lat/wr got %b/%0d/%0d exp 0/2/1", e, l, n);
    end
    ref_model(1'b0, 3'b010, 32'h0200_0008, 32'h0, ee, ed, el);
    issue(1'b0, 3'b010, 32'h0200_0008, 32'h0, e, d, l, n, rdy, idl);
    vectors++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
      miscompares++; $display("FAIL lw data got %h err %b exp deadbeef err 0", d, e);
    end
    vectors++;
    if (l !== 2 || n !== 0) begin
      miscompares++; $display("FAIL lw lat/wr got %0d/%0d exp 2/0", l, n);
    end
  endtask

  task automatic test_sb_rmw;
    logic e, ee, rdy, idl; logic [31:0] d, ed; int l, el, n;
    poke(2, 32'h1122_3344);
    ref_model(1'b1, 3'b000, 32'h0200_0009, 32'h5555_55AA, ee, ed, el);
    issue(1'b1, 3'b000, 32'h0200_0009, 32'h5555_55AA, e, d, l, n, rdy, idl);
    vectors++;
    if (mem[2] !== 32'h1122_AA44) begin
      miscompares++; $display("FAIL sb_merge got %h exp 1122aa44", mem[2]);
    end
    vectors++;
    if ({e, l, n} !== {1'b0, 3, 1}) begin
      miscompares++; $display("FAIL sb err/lat/wr got %b/%0d/%0d exp 0/3/1", e, l, n);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [6] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  offs[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] exps[6] = '{32'h0000_007F, 32'h0000_0001, 32'hFFFF_FFF0,
                             32'h0000_0080, 32'hFFFF_80F0, 32'h0000_80F0};
    logic e, ee, rdy, idl; logic [31:0] d, ed; int l, el, n;
    poke(4, 32'h80F0_017F);
    for (int i = 0; i < 6; i++) begin
      ref_model(1'b0, f3s[i], 32'h0200_0010 + 32'(offs[i]), 32'h0, ee, ed, el);
      issue(1'b0, f3s[i], 32'h0200_0010 + 32'(offs[i]), 32'h0, e, d, l, n, rdy, idl);
      vectors++;
      if (d !== exps[i] || e !== 1'b0) begin
        miscompares++;
        $display("FAIL load_ext[%0d] got %h err %b exp %h err 0", i, d, e, exps[i]);
      end
    end
  endtask

  task automatic test_err;
    logic        wes [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b100};
    logic [31:0] ads [3] = '{32'h0000_1000, 32'h0200_0020, 32'h0200_0020};
    logic e, ee, rdy, idl; logic [31:0] d, ed; int l, el, n;
    for (int i = 0; i < 3; i++) begin
      ref_model(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, ee, ed, el);
      issue(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, e, d, l, n, rdy, idl);
      vectors++;
      if ({e, d, l, n} !== {1'b1, 32'h0, 1, 0}) begin
        miscompares++;
        $display("FAIL err[%0d] got err %b data %h lat %0d wr %0d exp 1/0/1/0", i, e, d, l, n);
      end
    end
  endtask

  task automatic test_misalign;
    logic e, ee, rdy, idl; logic [31:0] d, ed, xd; logic xe; int l, el, n, xl;
    poke(1, 32'h1234_8765);
    ref_model(1'b0, 3'b001, 32'h0200_0005, 32'h0, ee, ed, el);
    issue(1'b0, 3'b001, 32'h0200_0005, 32'h0, e, d, l, n, rdy, idl);
`ifdef MISALIGN_TRAP_EN
    xe = 1'b1; xd = 32'h0; xl = 1;
`else
    xe = 1'b0; xd = 32'hFFFF_8765; xl = 2;
`endif
    vectors++;
    if ({e, d, l, n} !== {xe, xd, xl, 0}) begin
      miscompares++;
      $display("FAIL misalign_lh got %b/%h/%0d/%0d exp %b/%h/%0d/0", e, d, l, n, xe, xd, xl);
    end
  endtask

  task automatic test_reset_midflight;
    int wr0;
    poke(6, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0200_001A; req_wdata = 32'h0000_1234;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (mem_addr !== 32'h0200_0018 || mem_wr_en !== 1'b0) begin
      miscompares++; $display("FAIL sh_rmw_rd got addr %h we %b exp 02000018 0", mem_addr, mem_wr_en);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_wr_en, mem_addr, mem_wr_data, resp_rdata} !==
        {4'b1000, 96'h0}) begin
      miscompares++;
      $display("FAIL midreset_out got rdy %b vld %b we %b addr %h exp idle", req_ready,
               resp_valid, mem_wr_en, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (wr_count !== wr0 || mem[6] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL midreset_mem got %0d writes word %h exp 0 cafef00d", wr_count - wr0, mem[6]);
    end
  endtask

  task automatic test_back_to_back;
    logic e, ee, rdy, idl; logic [31:0] d, ed; int l, el, n;
    for (int i = 0; i < 4; i++) begin
      ref_model(i[0], 3'b010, Base + 32'(4 * i), 32'hA5A5_0000 + 32'(i), ee, ed, el);
      issue(i[0], 3'b010, Base + 32'(4 * i), 32'hA5A5_0000 + 32'(i), e, d, l, n, rdy, idl);
      vectors++;
      if (rdy !== 1'b1 || d !== ed || l !== el) begin
        miscompares++;
        $display("FAIL b2b[%0d] got rdy %b data %h lat %0d exp 1 %h %0d", i, rdy, d, l, ed, el);
      end
    end
  endtask

  task automatic test_random;
    logic e, ee, rdy, idl, we; logic [2:0] f3; logic [31:0] a, wd, d, ed; int l, el, n;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 32'h01FF_FFFF);
      else                           a = Base + $urandom_range(0, 255);
      ref_model(we, f3, a, wd, ee, ed, el);
      issue(we, f3, a, wd, e, d, l, n, rdy, idl);
      vectors++;
      if ({e, d, l, n, rdy, idl} !== {ee, ed, el, (we && !ee) ? 1 : 0, 2'b11}) begin
        miscompares++;
        $display("FAIL rand[%0d] we %b f3 %b a %h: got %b/%h/%0d/%0d/%b/%b exp %b/%h/%0d", i,
                 we, f3, a, e, d, l, n, rdy, idl, ee, ed, el);
      end
    end
    for (int w = 0; w < Words; w++) begin
      vectors++;
      if (mem[w] !== ref_mem[w]) begin
        miscompares++; $display("FAIL mem[%0d] got %h exp %h", w, mem[w], ref_mem[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    for (int w = 0; w < Words; w++) poke(w, $urandom);
    test_sw_lw();
    test_sb_rmw();
    test_load_ext();
    test_err();
    test_misalign();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
